// File: rtl/alu_operand_sequencer.sv
// Steps operands A, B and the opcode into an ALU using two debounced pushbuttons.
// Optional build macro ALU_SEQ_CHAIN_EN: in EXEC, a next-press feeds alu_res back into A.
module alu_operand_sequencer #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] sw,
    input  logic       btn_next,
    input  logic       btn_clr,
    input  logic [3:0] alu_res,
    output logic [3:0] a,
    output logic [3:0] b,
    output logic [2:0] opcode,
    output logic       in_sel,
    output logic [1:0] state_led,
    output logic       exec_valid
);

    // state   | meaning
    // LOAD_A  | waiting for operand A on sw
    // LOAD_B  | waiting for operand B on sw
    // LOAD_OP | waiting for opcode/in_sel on sw
    // EXEC    | operands presented to the ALU
    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        LOAD_OP = 2'd2,
        EXEC    = 2'd3
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(DEBOUNCE_CYCLES - 1);

    // Bit 0 is btn_next, bit 1 is btn_clr.
    logic [1:0]  btn_raw;
    logic [1:0]  sync1, sync2, deb, deb_q;
    logic [15:0] cnt [2];
    logic [1:0]  press;
    logic        next_press, clr_press;

    assign btn_raw    = {btn_clr, btn_next};
    assign press      = deb & ~deb_q;
    assign next_press = press[0];
    assign clr_press  = press[1];

    // The accept happens on the DEBOUNCE_CYCLES-th consecutive differing cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= '0;
            sync2  <= '0;
            deb    <= '0;
            deb_q  <= '0;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
            deb_q <= deb;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    deb[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 16'd1;
                end
            end
        end
    end

    state_t     state, state_nxt;
    logic [3:0] a_nxt, b_nxt;
    logic [2:0] opcode_nxt;
    logic       in_sel_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= LOAD_A;
            a          <= '0;
            b          <= '0;
            opcode     <= '0;
            in_sel     <= 1'b0;
            exec_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            a          <= a_nxt;
            b          <= b_nxt;
            opcode     <= opcode_nxt;
            in_sel     <= in_sel_nxt;
            exec_valid <= (state_nxt == EXEC) && (state != EXEC);
        end
    end

    always_comb begin
        state_nxt  = state;
        a_nxt      = a;
        b_nxt      = b;
        opcode_nxt = opcode;
        in_sel_nxt = in_sel;
        if (clr_press) begin
            state_nxt  = LOAD_A;
            a_nxt      = '0;
            b_nxt      = '0;
            opcode_nxt = '0;
            in_sel_nxt = 1'b0;
        end else if (next_press) begin
            case (state)
                LOAD_A: begin
                    a_nxt     = sw;
                    state_nxt = LOAD_B;
                end
                LOAD_B: begin
                    b_nxt     = sw;
                    state_nxt = LOAD_OP;
                end
                LOAD_OP: begin
                    opcode_nxt = sw[2:0];
                    in_sel_nxt = sw[3];
                    state_nxt  = EXEC;
                end
                EXEC: begin
`ifdef ALU_SEQ_CHAIN_EN
                    a_nxt     = alu_res;
                    state_nxt = LOAD_B;
`else
                    state_nxt = LOAD_A;
`endif
                end
                default: state_nxt = LOAD_A;
            endcase
        end
    end

`ifndef ALU_SEQ_CHAIN_EN
    logic unused_alu_res;
    assign unused_alu_res = ^alu_res;
`endif

    assign state_led = state;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Directed bench for alu_operand_sequencer with DEBOUNCE_CYCLES=4; honours ALU_SEQ_CHAIN_EN.
module tb_alu_operand_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] sw;
    logic       btn_next, btn_clr;
    logic [3:0] alu_res;
    logic [3:0] a, b;
    logic [2:0] opcode;
    logic       in_sel;
    logic [1:0] state_led;
    logic       exec_valid;

    alu_operand_sequencer #(.DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .sw(sw), .btn_next(btn_next), .btn_clr(btn_clr),
        .alu_res(alu_res), .a(a), .b(b), .opcode(opcode), .in_sel(in_sel),
        .state_led(state_led), .exec_valid(exec_valid)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int ev_cnt = 0;

    always @(negedge clk) if (exec_valid === 1'b1) ev_cnt++;

    typedef struct {
        logic       clr;
        logic [3:0] sw;
        logic [3:0] alu;
        logic [3:0] ea, eb;
        logic [2:0] eop;
        logic       eis;
        logic [1:0] est;
        int         eev;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_regs(input string nm, input int ea, input int eb, input int eop,
                            input int eis, input int est);
        chk({nm, ".a"}, int'(a), ea);
        chk({nm, ".b"}, int'(b), eb);
        chk({nm, ".opcode"}, int'(opcode), eop);
        chk({nm, ".in_sel"}, int'(in_sel), eis);
        chk({nm, ".state"}, int'(state_led), est);
    endtask

    // Called at a negedge; leaves both buttons released and settled.
    task automatic press(input logic do_next, input logic do_clr, input logic [3:0] s);
        sw       = s;
        btn_next = do_next;
        btn_clr  = do_clr;
        repeat (10) @(negedge clk);
        btn_next = 1'b0;
        btn_clr  = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic edges_until_change(input logic [1:0] from, output int n);
        n = 0;
        while (state_led == from && n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    function automatic vec_t mk(input logic clr, input logic [3:0] s, input logic [3:0] alu,
                                input logic [3:0] ea, input logic [3:0] eb, input logic [2:0] eop,
                                input logic eis, input logic [1:0] est, input int eev);
        vec_t v;
        v.clr = clr; v.sw = s; v.alu = alu; v.ea = ea; v.eb = eb;
        v.eop = eop; v.eis = eis; v.est = est; v.eev = eev;
        return v;
    endfunction

    initial begin
        int n;
        int ev0;
        vecs[0] = mk(0, 4'h5, 4'h0, 4'h5, 4'h0, 3'd0, 0, 2'd1, 0);
        vecs[1] = mk(0, 4'h3, 4'h0, 4'h5, 4'h3, 3'd0, 0, 2'd2, 0);
        vecs[2] = mk(0, 4'h1, 4'h0, 4'h5, 4'h3, 3'd1, 0, 2'd3, 1);
`ifdef ALU_SEQ_CHAIN_EN
        vecs[3] = mk(0, 4'hF, 4'h8, 4'h8, 4'h3, 3'd1, 0, 2'd1, 0);
`else
        vecs[3] = mk(0, 4'hF, 4'h8, 4'h5, 4'h3, 3'd1, 0, 2'd0, 0);
`endif
        vecs[4] = mk(1, 4'h7, 4'h0, 4'h0, 4'h0, 3'd0, 0, 2'd0, 0);
        vecs[5] = mk(0, 4'hA, 4'h0, 4'hA, 4'h0, 3'd0, 0, 2'd1, 0);
        vecs[6] = mk(0, 4'hC, 4'h0, 4'hA, 4'hC, 3'd0, 0, 2'd2, 0);
        vecs[7] = mk(0, 4'hE, 4'h0, 4'hA, 4'hC, 3'd6, 1, 2'd3, 1);
        vecs[8] = mk(1, 4'h0, 4'h0, 4'h0, 4'h0, 3'd0, 0, 2'd0, 0);

        rst_n = 1'b0; sw = 4'h0; btn_next = 1'b0; btn_clr = 1'b0; alu_res = 4'h0;
        repeat (3) @(negedge clk);
        chk_regs("in_reset", 0, 0, 0, 0, 0);
        chk("in_reset.exec_valid", int'(exec_valid), 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk_regs("idle", 0, 0, 0, 0, 0);
        chk("idle.exec_pulses", ev_cnt, 0);

        for (int i = 0; i < 9; i++) begin
            alu_res = vecs[i].alu;
            ev0 = ev_cnt;
            press(!vecs[i].clr, vecs[i].clr, vecs[i].sw);
            chk_regs($sformatf("vec%0d", i), int'(vecs[i].ea), int'(vecs[i].eb),
                     int'(vecs[i].eop), int'(vecs[i].eis), int'(vecs[i].est));
            chk($sformatf("vec%0d.exec_pulses", i), ev_cnt - ev0, vecs[i].eev);
        end
        alu_res = 4'h0;

        // Short glitch must not qualify.
        btn_next = 1'b1;
        repeat (3) @(negedge clk);
        btn_next = 1'b0;
        repeat (20) @(negedge clk);
        chk_regs("glitch", 0, 0, 0, 0, 0);

        // Press pulse six cycles after the raw edge, so the state moves on the seventh edge.
        sw = 4'h7;
        btn_next = 1'b1;
        edges_until_change(2'd0, n);
        chk("latency_edges", n, 7);
        @(negedge clk);
        repeat (3) @(negedge clk);
        btn_next = 1'b0;
        repeat (20) @(negedge clk);
        chk_regs("long_hold", 7, 0, 0, 0, 1);

        sw = 4'hF;
        repeat (10) @(negedge clk);
        chk_regs("sw_no_press", 7, 0, 0, 0, 1);

        // Reach LOAD_OP, then coincident clr and next.
        press(1'b1, 1'b0, 4'h2);
        chk_regs("pre_coincide", 7, 2, 0, 0, 2);
        ev0 = ev_cnt;
        press(1'b1, 1'b1, 4'h9);
        chk_regs("coincide", 0, 0, 0, 0, 0);
        chk("coincide.exec_pulses", ev_cnt - ev0, 0);

        // Reset mid-sequence and mid-debounce.
        press(1'b1, 1'b0, 4'h5);
        press(1'b1, 1'b0, 4'h6);
        chk_regs("pre_reset", 5, 6, 0, 0, 2);
        btn_next = 1'b1;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_regs("async_reset", 0, 0, 0, 0, 0);
        chk("async_reset.exec_valid", int'(exec_valid), 0);
        repeat (3) @(negedge clk);
        sw = 4'h4;
        rst_n = 1'b1;
        edges_until_change(2'd0, n);
        chk("post_reset_latency", n, 7);
        btn_next = 1'b0;
        repeat (20) @(negedge clk);
        chk_regs("post_reset", 4, 0, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
